// File: rtl/dma_csr_pkg.sv
// Shared register map, bit positions and channel configuration type for the
// multi-channel DMA CSR block.
package dma_csr_pkg;

  // Byte offsets inside one channel window
  localparam logic [31:0] OFF_SRC_LO   = 32'h00;
  localparam logic [31:0] OFF_SRC_HI   = 32'h04;
  localparam logic [31:0] OFF_DST_LO   = 32'h08;
  localparam logic [31:0] OFF_DST_HI   = 32'h0C;
  localparam logic [31:0] OFF_LEN      = 32'h10;
  localparam logic [31:0] OFF_CTRL     = 32'h14;
  localparam logic [31:0] OFF_DESC_PTR = 32'h18;
  localparam logic [31:0] OFF_STATUS   = 32'h1C;

  // Byte offsets inside the global window
  localparam logic [31:0] GLB_IRQ_STATUS = 32'h0;
  localparam logic [31:0] GLB_IRQ_MASK   = 32'h4;
  localparam logic [31:0] GLB_INFO       = 32'h8;

  localparam int CTRL_START     = 0;
  localparam int CTRL_DESC_MODE = 1;

  localparam int STAT_BUSY = 0;
  localparam int STAT_DONE = 1;
  localparam int STAT_ERR  = 2;

  localparam logic [15:0] INFO_MAGIC   = 16'h0D4A;
  localparam logic [7:0]  INFO_VERSION = 8'h01;

  // Addresses are held at the widest supported size; unstored high bits stay 0.
  typedef struct packed {
    logic [63:0] src;
    logic [63:0] dst;
    logic [31:0] len;
    logic [31:0] desc_ptr;
    logic        desc_mode;
  } ch_cfg_t;

endpackage

// File: rtl/dma_csr_chan.sv
// One DMA channel's register window: configuration, busy/done/err tracking,
// start pulse generation and interrupt set request.
module dma_csr_chan
  import dma_csr_pkg::*;
#(
  parameter int ADDR_W = 48
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic [31:0]       off,
  input  logic [31:0]       wdata,
  input  logic              done_pulse,
  output logic [31:0]       rdata,
  output logic              start,
  output logic [ADDR_W-1:0] src,
  output logic [ADDR_W-1:0] dst,
  output logic [31:0]       len,
  output logic              desc_mode,
  output logic [31:0]       desc_ptr,
  output logic              irq_set
);

  localparam int          HI_W    = ADDR_W - 32;
  localparam logic [31:0] HI_MASK = 32'((64'd1 << HI_W) - 64'd1);

  ch_cfg_t cfg_q, cfg_d;
  logic    busy_q, done_q, err_q, start_q;

  logic done_evt, busy_eff, is_cfg_wr, start_wr, start_acc, cfg_rej, status_wr;

  // A completion in the same cycle is handled before any write, so a
  // START arriving alongside it sees the channel as idle.
  assign done_evt  = done_pulse & busy_q;
  assign busy_eff  = busy_q & ~done_evt;
  assign is_cfg_wr = wr_en & ((off == OFF_SRC_LO) || (off == OFF_SRC_HI) ||
                              (off == OFF_DST_LO) || (off == OFF_DST_HI) ||
                              (off == OFF_LEN)    || (off == OFF_DESC_PTR) ||
                              (off == OFF_CTRL));
  assign start_wr  = wr_en & (off == OFF_CTRL) & wdata[CTRL_START];
  assign start_acc = start_wr & ~busy_eff;
  assign cfg_rej   = is_cfg_wr & busy_eff;
  assign status_wr = wr_en & (off == OFF_STATUS);

  always_comb begin
    // NOTE: default assignment first so no path leaves cfg_d unassigned (no latch).
    cfg_d = cfg_q;
    if (is_cfg_wr && !busy_eff) begin
      case (off)
        OFF_SRC_LO:   cfg_d.src[31:0]  = wdata;
        OFF_SRC_HI:   cfg_d.src[63:32] = wdata & HI_MASK;
        OFF_DST_LO:   cfg_d.dst[31:0]  = wdata;
        OFF_DST_HI:   cfg_d.dst[63:32] = wdata & HI_MASK;
        OFF_LEN:      cfg_d.len        = wdata;
        OFF_DESC_PTR: cfg_d.desc_ptr   = wdata;
        OFF_CTRL:     cfg_d.desc_mode  = wdata[CTRL_DESC_MODE];
        default:      cfg_d = cfg_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cfg_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      start_q <= 1'b0;
    end else begin
      // NOTE: non-blocking for all state so every flop samples pre-edge values.
      cfg_q   <= cfg_d;
      start_q <= start_acc;

      if (start_acc)     busy_q <= 1'b1;
      else if (done_evt) busy_q <= 1'b0;

      // Hardware set beats W1C; an accepted START opens a fresh transfer.
      if (start_acc)                            done_q <= 1'b0;
      else if (done_evt)                        done_q <= 1'b1;
      else if (status_wr && wdata[STAT_DONE])   done_q <= 1'b0;

      if (cfg_rej)                              err_q <= 1'b1;
      else if (status_wr && wdata[STAT_ERR])    err_q <= 1'b0;
    end
  end

  always_comb begin
    rdata = '0;
    case (off)
      OFF_SRC_LO:   rdata = cfg_q.src[31:0];
      OFF_SRC_HI:   rdata = cfg_q.src[63:32];
      OFF_DST_LO:   rdata = cfg_q.dst[31:0];
      OFF_DST_HI:   rdata = cfg_q.dst[63:32];
      OFF_LEN:      rdata = cfg_q.len;
      OFF_DESC_PTR: rdata = cfg_q.desc_ptr;
      OFF_CTRL:     rdata = {30'b0, cfg_q.desc_mode, 1'b0};
      OFF_STATUS:   rdata = {29'b0, err_q, done_q, busy_q};
      default:      rdata = '0;
    endcase
  end

  assign start     = start_q;
  assign src       = cfg_q.src[ADDR_W-1:0];
  assign dst       = cfg_q.dst[ADDR_W-1:0];
  assign len       = cfg_q.len;
  assign desc_mode = cfg_q.desc_mode;
  assign desc_ptr  = cfg_q.desc_ptr;
  assign irq_set   = done_evt;

endmodule

// File: rtl/dma_csr_mc.sv
// Multi-channel DMA CSR front-end: cfg bus decode, registered responses,
// per-channel register windows and the aggregated interrupt.
module dma_csr_mc
  import dma_csr_pkg::*;
#(
  parameter int          NUM_CH    = 4,
  parameter int          ADDR_W    = 48,
  parameter logic [31:0] CH_STRIDE = 32'h40,
  parameter logic [31:0] GLB_BASE  = 32'h400
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     cfg_req_valid,
  input  logic                     cfg_req_we,
  input  logic [31:0]              cfg_req_addr,
  input  logic [31:0]              cfg_req_wdata,
  output logic                     cfg_resp_valid,
  output logic [31:0]              cfg_resp_rdata,
  output logic [NUM_CH-1:0]        ch_start,
  output logic [NUM_CH*ADDR_W-1:0] ch_src,
  output logic [NUM_CH*ADDR_W-1:0] ch_dst,
  output logic [NUM_CH*32-1:0]     ch_len,
  output logic [NUM_CH-1:0]        ch_desc_mode,
  output logic [NUM_CH*32-1:0]     ch_desc_ptr,
  input  logic [NUM_CH-1:0]        ch_done,
  output logic                     irq
);

  logic        wr, glb_hit;
  logic [31:0] glb_off, ch_idx, ch_off, rd_data;
  logic [31:0] ch_rdata [NUM_CH];
  logic [NUM_CH-1:0] irq_set, irq_status, irq_mask, irq_w1c;

  // The global window is checked first so it can never alias a channel.
  assign wr      = cfg_req_valid & cfg_req_we;
  assign glb_off = cfg_req_addr - GLB_BASE;
  assign glb_hit = (cfg_req_addr >= GLB_BASE) && (glb_off < 32'hC);
  assign ch_idx  = cfg_req_addr / CH_STRIDE;
  assign ch_off  = cfg_req_addr % CH_STRIDE;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    dma_csr_chan #(.ADDR_W(ADDR_W)) u_chan (
      .clk        (clk),
      .rst_n      (rst_n),
      .wr_en      (wr && !glb_hit && (ch_idx == 32'(i))),
      .off        (ch_off),
      .wdata      (cfg_req_wdata),
      .done_pulse (ch_done[i]),
      .rdata      (ch_rdata[i]),
      .start      (ch_start[i]),
      .src        (ch_src[i*ADDR_W +: ADDR_W]),
      .dst        (ch_dst[i*ADDR_W +: ADDR_W]),
      .len        (ch_len[i*32 +: 32]),
      .desc_mode  (ch_desc_mode[i]),
      .desc_ptr   (ch_desc_ptr[i*32 +: 32]),
      .irq_set    (irq_set[i])
    );
  end

  assign irq_w1c = (wr && glb_hit && (glb_off == GLB_IRQ_STATUS)) ?
                   cfg_req_wdata[NUM_CH-1:0] : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      irq_status <= '0;
      irq_mask   <= '0;
      irq        <= 1'b0;
    end else begin
      irq_status <= irq_set | (irq_status & ~irq_w1c);
      if (wr && glb_hit && (glb_off == GLB_IRQ_MASK))
        irq_mask <= cfg_req_wdata[NUM_CH-1:0];
      irq        <= |(irq_status & irq_mask);
    end
  end

  always_comb begin
    rd_data = '0;
    if (glb_hit) begin
      case (glb_off)
        GLB_IRQ_STATUS: rd_data = 32'(irq_status);
        GLB_IRQ_MASK:   rd_data = 32'(irq_mask);
        GLB_INFO:       rd_data = {INFO_MAGIC, 8'(NUM_CH), INFO_VERSION};
        default:        rd_data = '0;
      endcase
    end else begin
      for (int i = 0; i < NUM_CH; i++)
        if (ch_idx == 32'(i)) rd_data = ch_rdata[i];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cfg_resp_valid <= 1'b0;
      cfg_resp_rdata <= '0;
    end else begin
      cfg_resp_valid <= cfg_req_valid;
      cfg_resp_rdata <= (cfg_req_valid && !cfg_req_we) ? rd_data : '0;
    end
  end

endmodule

// File: tb/tb_dma_csr_mc.sv
// Directed bench for dma_csr_mc: bus responses go through an expected-value
// queue, side-band outputs are compared at fixed points in the sequence.
module tb_dma_csr_mc;

  localparam int NUM_CH = 4;
  localparam int ADDR_W = 48;

  logic                     clk = 1'b0;
  logic                     rst_n = 1'b0;
  logic                     cfg_req_valid = 1'b0;
  logic                     cfg_req_we = 1'b0;
  logic [31:0]              cfg_req_addr = '0;
  logic [31:0]              cfg_req_wdata = '0;
  logic                     cfg_resp_valid;
  logic [31:0]              cfg_resp_rdata;
  logic [NUM_CH-1:0]        ch_start;
  logic [NUM_CH*ADDR_W-1:0] ch_src;
  logic [NUM_CH*ADDR_W-1:0] ch_dst;
  logic [NUM_CH*32-1:0]     ch_len;
  logic [NUM_CH-1:0]        ch_desc_mode;
  logic [NUM_CH*32-1:0]     ch_desc_ptr;
  logic [NUM_CH-1:0]        ch_done = '0;
  logic                     irq;

  dma_csr_mc #(.NUM_CH(NUM_CH), .ADDR_W(ADDR_W)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .cfg_req_valid  (cfg_req_valid),
    .cfg_req_we     (cfg_req_we),
    .cfg_req_addr   (cfg_req_addr),
    .cfg_req_wdata  (cfg_req_wdata),
    .cfg_resp_valid (cfg_resp_valid),
    .cfg_resp_rdata (cfg_resp_rdata),
    .ch_start       (ch_start),
    .ch_src         (ch_src),
    .ch_dst         (ch_dst),
    .ch_len         (ch_len),
    .ch_desc_mode   (ch_desc_mode),
    .ch_desc_ptr    (ch_desc_ptr),
    .ch_done        (ch_done),
    .irq            (irq)
  );

  always #5 clk = ~clk;

  int          n_vec = 0;
  int          n_err = 0;
  logic [31:0] exp_q[$];

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One bus transaction; the expected read data is queued when driven and
  // popped when the response appears one edge later.
  task automatic bus(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                     input logic [31:0] exp, input string tag);
    logic [31:0] e;
    @(negedge clk);
    cfg_req_valid = 1'b1;
    cfg_req_we    = we;
    cfg_req_addr  = addr;
    cfg_req_wdata = wdata;
    exp_q.push_back(we ? 32'h0 : exp);
    @(posedge clk);
    #1;
    cfg_req_valid = 1'b0;
    cfg_req_we    = 1'b0;
    check({tag, "_vld"}, 256'(cfg_resp_valid), 256'(1'b1));
    if (exp_q.size() == 0) begin
      n_vec++;
      n_err++;
      $error("FAIL %s_sb: observed empty queue expected entry", tag);
    end else begin
      e = exp_q.pop_front();
      check(tag, 256'(cfg_resp_rdata), 256'(e));
    end
  endtask

  task automatic wr(input logic [31:0] addr, input logic [31:0] data, input string tag);
    bus(1'b1, addr, data, 32'h0, tag);
  endtask

  task automatic rd(input logic [31:0] addr, input logic [31:0] exp, input string tag);
    bus(1'b0, addr, 32'h0, exp, tag);
  endtask

  task automatic idle();
    @(posedge clk);
    #1;
    check("idle_vld", 256'(cfg_resp_valid), 256'(1'b0));
  endtask

  task automatic pulse_done(input logic [NUM_CH-1:0] v);
    @(negedge clk);
    ch_done = v;
    @(posedge clk);
    #1;
    ch_done = '0;
  endtask

  initial begin
    // Reset state
    #1;
    check("rst_start", 256'(ch_start), 256'(0));
    check("rst_src", 256'(ch_src), 256'(0));
    check("rst_len", 256'(ch_len), 256'(0));
    check("rst_irq", 256'(irq), 256'(0));
    check("rst_vld", 256'(cfg_resp_valid), 256'(0));
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Channel 1 programming and start; unstored SRC_HI bits read back 0
    wr(32'h40, 32'h1000_0000, "c1_src_lo");
    wr(32'h44, 32'hFFFF_0012, "c1_src_hi");
    wr(32'h50, 32'h0000_0100, "c1_len");
    rd(32'h44, 32'h0000_0012, "c1_src_hi_rd");
    wr(32'h54, 32'h1, "c1_ctrl");
    check("c1_pulse", 256'(ch_start), 256'(4'b0010));
    idle();
    check("c1_pulse_end", 256'(ch_start), 256'(0));
    check("c1_src_out", 256'(ch_src[1*ADDR_W +: ADDR_W]), 256'(48'h0012_1000_0000));
    check("c1_len_out", 256'(ch_len[1*32 +: 32]), 256'(32'h100));
    rd(32'h5C, 32'h1, "c1_stat_busy");

    // Write-protection while busy
    wr(32'h50, 32'h0000_0200, "c1_len_busy");
    wr(32'h54, 32'h1, "c1_ctrl_busy");
    check("c1_no_pulse", 256'(ch_start), 256'(0));
    check("c1_len_kept", 256'(ch_len[1*32 +: 32]), 256'(32'h100));
    rd(32'h50, 32'h100, "c1_len_rd");
    rd(32'h5C, 32'h5, "c1_stat_err");
    wr(32'h5C, 32'h4, "c1_err_w1c");
    rd(32'h5C, 32'h1, "c1_stat_clr");

    // Completion, irq with mask, W1C of irq status
    wr(32'h404, 32'h2, "mask_2");
    pulse_done(4'b0010);
    check("irq_lag", 256'(irq), 256'(0));
    rd(32'h5C, 32'h2, "c1_stat_done");
    check("irq_rise", 256'(irq), 256'(1));
    rd(32'h400, 32'h2, "irqst_2");
    wr(32'h400, 32'h2, "irqst_w1c");
    idle();
    check("irq_fall", 256'(irq), 256'(0));

    // Channel 2 with dst/desc config, completion masked then unmasked
    wr(32'h88, 32'hDEAD_BEEF, "c2_dst_lo");
    wr(32'h8C, 32'h0000_ABCD, "c2_dst_hi");
    wr(32'h98, 32'h0000_8000, "c2_desc_ptr");
    wr(32'h94, 32'h1, "c2_ctrl");
    check("c2_pulse", 256'(ch_start), 256'(4'b0100));
    check("c2_dst_out", 256'(ch_dst[2*ADDR_W +: ADDR_W]), 256'(48'hABCD_DEAD_BEEF));
    check("c2_dptr_out", 256'(ch_desc_ptr[2*32 +: 32]), 256'(32'h8000));
    pulse_done(4'b0100);
    rd(32'h400, 32'h4, "irqst_4");
    idle();
    check("irq_masked", 256'(irq), 256'(0));
    wr(32'h404, 32'h4, "mask_4");
    idle();
    check("irq_unmasked", 256'(irq), 256'(1));

    // Completion on an idle channel is ignored
    pulse_done(4'b1000);
    rd(32'h DC, 32'h0, "c3_stat_idle");
    rd(32'h400, 32'h4, "irqst_still_4");

    // Hardware set beats W1C on the same irq_status bit
    wr(32'h14, 32'h1, "c0_ctrl");
    check("c0_pulse", 256'(ch_start), 256'(4'b0001));
    ch_done = 4'b0001;
    wr(32'h400, 32'h1, "irqst_w1c_race");
    ch_done = '0;
    rd(32'h400, 32'h5, "irqst_set_wins");

    // START and completion in the same cycle: start accepted
    wr(32'h54, 32'h1, "c1_restart");
    check("c1_pulse2", 256'(ch_start), 256'(4'b0010));
    idle();
    ch_done = 4'b0010;
    wr(32'h54, 32'h1, "c1_start_done");
    ch_done = '0;
    check("c1_pulse3", 256'(ch_start), 256'(4'b0010));
    rd(32'h400, 32'h7, "irqst_7");

    // INFO and unmapped space
    rd(32'h408, 32'h0D4A_0401, "info");
    wr(32'h3FC, 32'hFFFF_FFFF, "unmapped_wr");
    rd(32'h3FC, 32'h0, "unmapped_3fc");
    rd(32'h120, 32'h0, "ch4_src_lo");
    rd(32'h60, 32'h0, "c1_off20");
    rd(32'h40C, 32'h0, "glb_off_c");

    // Asynchronous reset during a start pulse
    wr(32'hD4, 32'h3, "c3_ctrl");
    check("c3_pulse", 256'(ch_start), 256'(4'b1000));
    check("c3_mode", 256'(ch_desc_mode), 256'(4'b1000));
    rst_n = 1'b0;
    #1;
    check("arst_start", 256'(ch_start), 256'(0));
    check("arst_src", 256'(ch_src), 256'(0));
    check("arst_len", 256'(ch_len), 256'(0));
    check("arst_mode", 256'(ch_desc_mode), 256'(0));
    check("arst_irq", 256'(irq), 256'(0));
    check("arst_vld", 256'(cfg_resp_valid), 256'(0));
    @(negedge clk);
    rst_n = 1'b1;
    rd(32'h5C, 32'h0, "c1_stat_rst");
    rd(32'h404, 32'h0, "mask_rst");
    rd(32'h400, 32'h0, "irqst_rst");
    rd(32'h40, 32'h0, "c1_src_rst");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/dma_csr_mc.md
Name: dma_csr_mc

Overview:
Multi-channel MMIO configuration/status block for the DMA subsystem. It generalises the single-channel register front-end to NUM_CH independent channels, and adds:
- explicit read/write requests with registered responses;
- per-channel busy/done/error tracking;
- write-protection of channel registers while a channel is busy;
- W1C sticky IRQ status with a mask.

It sits between the host cfg bus and NUM_CH DMA engine instances and drives one aggregated interrupt line.

Parameters:
NUM_CH, 4, number of DMA channels (1..16)
ADDR_W, 48, width of src/dst address fields presented to each channel (33..64)
CH_STRIDE, 32'h40, byte spacing of per-channel register windows
GLB_BASE, 32'h400, byte address of the global register window

Ports:
clk  in  1  clock
rst_n  in  1  reset, asynchronous, active-low
cfg_req_valid  in  1  request strobe, one request per cycle
cfg_req_we  in  1  1 = write, 0 = read
cfg_req_addr  in  32  byte address, word-aligned
cfg_req_wdata  in  32  write data
cfg_resp_valid  out  1  response strobe, one cycle after request
cfg_resp_rdata  out  32  read data (0 for writes)
ch_start  out  NUM_CH  one-cycle start pulse per channel
ch_src  out  NUM_CH*ADDR_W  per-channel source address
ch_dst  out  NUM_CH*ADDR_W  per-channel destination address
ch_len  out  NUM_CH*32  per-channel byte length
ch_desc_mode  out  NUM_CH  per-channel descriptor mode
ch_desc_ptr  out  NUM_CH*32  per-channel descriptor table pointer
ch_done  in  NUM_CH  one-cycle completion pulse from each engine
irq  out  1  registered OR of (irq_status & irq_mask)

Behaviour:
- Reset: all outputs 0. All registers 0, including busy, err, irq_status and irq_mask.
- Per-channel window at ch*CH_STRIDE, offsets:
  - 0x00 SRC_LO, 0x04 SRC_HI (only bits ADDR_W-33:0 stored; rest read 0).
  - 0x08 DST_LO, 0x0C DST_HI (same rule as SRC_HI).
  - 0x10 LEN, 0x18 DESC_PTR.
  - 0x14 CTRL: bit0 START (write-1, reads 0), bit1 DESC_MODE (RW).
  - 0x1C STATUS: bit0 busy RO, bit1 done sticky W1C, bit2 err sticky W1C.
- Global window at GLB_BASE:
  - +0x0 IRQ_STATUS: NUM_CH bits, W1C.
  - +0x4 IRQ_MASK: RW.
  - +0x8 INFO: RO, {16'h0D4A, 8'(NUM_CH), 8'h01}.
- Channel index ≥ NUM_CH, or any unmapped offset: writes ignored, reads return 0. No error response.
- Response: cfg_resp_valid asserted exactly 1 cycle after each cfg_req_valid. Read data reflects register state before any same-cycle update.
- START write with busy=0:
  - ch_start pulses high for exactly the next cycle;
  - busy set the same edge;
  - done cleared.
- START write with busy=1: no pulse; err set.
- Writes to SRC/DST/LEN/DESC_PTR/DESC_MODE while busy=1: dropped, err set. ch_* outputs stay stable for the whole transfer.
- ch_done[i] pulse:
  - busy cleared, done set, irq_status[i] set on the next edge.
  - ch_done while busy=0 is ignored (no status change).
- Same-cycle W1C and hardware set of the same irq_status/done bit: set wins.
- Same-cycle START write and ch_done on the same channel: done processed first, so the start is accepted (busy remains 1, new pulse issued).
- irq: registered, rises 1 cycle after irq_status&irq_mask becomes non-zero. Masking a pending bit drops irq on the next edge.
- Reset mid-transfer: all state cleared immediately (async); any in-progress ch_start pulse aborted.

Decomposition:
- dma_csr_pkg holds:
  - register offset localparams (OFF_SRC_LO … OFF_STATUS, GLB_IRQ_STATUS/MASK/INFO);
  - CTRL/STATUS bit-index constants;
  - INFO magic constant;
  - typedef struct ch_cfg_t {src, dst, len, desc_ptr, desc_mode}.
- Sub-module dma_csr_chan, one generate instance per channel:
  - owns that channel's registers, busy/done/err, start pulse and irq set request;
  - top level does address decode, read mux, response register, global irq logic.

Test Plan:
- Write ch1 SRC_LO=0x1000_0000, SRC_HI=0x0000_0012, LEN=0x100, then CTRL=1 -> ch_start[1] pulses 1 cycle; ch_src[1]=48'h0012_1000_0000; STATUS(ch1) reads 0x1.
- With ch1 busy: write LEN=0x200 and CTRL=1 -> ch_len[1] stays 0x100, no pulse, STATUS reads 0x5. Write STATUS=0x4 -> reads 0x1.
- IRQ_MASK=0x2; pulse ch_done[1] -> STATUS=0x2, IRQ_STATUS=0x2, irq=1 one cycle later. Write IRQ_STATUS=0x2 -> irq=0 next cycle.
- Pulse ch_done[2] with mask 0x2 -> IRQ_STATUS=0x4, irq stays 0. Write mask 0x4 -> irq=1.
- Same cycle: ch_done[0] and IRQ_STATUS W1C of 0x1 -> bit0 remains 1.
- Read INFO with NUM_CH=4 -> 0x0D4A_0401. Read 0x3FC -> 0. Assert rst_n low mid-transfer -> all outputs 0, busy cleared.
